// File: rtl/dmem_pkg.sv
// dmem_responder shared types: funct3 codes, FSM states, wait limit.
// Misaligned-access trapping is selected with DMEM_MISALIGN_TRAP_EN.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  function automatic int clamp_wait(int w);
    if (w > MAX_WAIT) return MAX_WAIT;
    if (w < 0) return 0;
    return w;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store request and response bundle between core and data memory.
// The core side uses master, the memory side uses slave.
interface dmem_if #(
  parameter int ADDR_W = 7
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid,
    output req_we,
    output req_funct3,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_funct3,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );

endinterface

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane decode and load extension for dmem_responder.
// With DMEM_MISALIGN_TRAP_EN misaligned half/word accesses are errors.
module dmem_lane_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       raw,
  output logic [3:0]        be,
  output logic [ADDR_W-1:0] addr_al,
  output logic              err,
  output logic [31:0]       rdata
);

  logic is_b;
  logic is_h;
  logic is_w;
  logic is_bu;
  logic is_hu;
  logic legal;

  always_comb begin
    is_b  = (funct3 == F3_B);
    is_h  = (funct3 == F3_H);
    is_w  = (funct3 == F3_W);
    is_bu = (funct3 == F3_BU);
    is_hu = (funct3 == F3_HU);
    legal = is_b | is_h | is_w
          | (~we & (is_bu | is_hu));

    err = ~legal;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((is_h | is_hu) & addr[0])
      err = 1'b1;
    if (is_w & (|addr[1:0]))
      err = 1'b1;
`endif

    // without trapping, low bits are silently dropped
    addr_al = addr;
    if (is_h | is_hu)
      addr_al[0] = 1'b0;
    if (is_w)
      addr_al[1:0] = 2'b00;

    be = 4'b0000;
    if (we & ~err) begin
      unique case (1'b1)
        is_b:    be = 4'b0001;
        is_h:    be = 4'b0011;
        is_w:    be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end

    rdata = '0;
    if (~we & ~err) begin
      unique case (1'b1)
        is_b:  rdata = {{24{raw[7]}}, raw[7:0]};
        is_h:  rdata = {{16{raw[15]}}, raw[15:0]};
        is_w:  rdata = raw;
        is_bu: rdata = {24'h0, raw[7:0]};
        is_hu: rdata = {16'h0, raw[15:0]};
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one serialized load/store per handshake,
// answered after WAIT_CYCLES wait states. Option: DMEM_MISALIGN_TRAP_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int WAIT_CYCLES = 0
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int WC    = clamp_wait(WAIT_CYCLES);
  localparam logic [3:0] CNT_INIT =
    (WC > 0) ? 4'(WC - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [7:0] mem_q [DEPTH] = '{default: 8'h00};

  logic [3:0]        be;
  logic [ADDR_W-1:0] addr_al;
  logic              lane_err;
  logic [31:0]       raw;
  logic [31:0]       ext;
  logic              do_resp;

  dmem_lane_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_lane (
    .we      (we_q),
    .funct3  (f3_q),
    .addr    (addr_q),
    .raw     (raw),
    .be      (be),
    .addr_al (addr_al),
    .err     (lane_err),
    .rdata   (ext)
  );

  assign raw = {
    mem_q[addr_al + ADDR_W'(3)],
    mem_q[addr_al + ADDR_W'(2)],
    mem_q[addr_al + ADDR_W'(1)],
    mem_q[addr_al]
  };

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = CNT_INIT;
          state_d = (WC > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0)
          state_d = RESP;
        else
          cnt_d = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    do_resp       = (state_q == RESP);
    rsp_valid_d   = do_resp;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    if (do_resp) begin
      rsp_rdata_d = ext;
      rsp_err_d   = lane_err;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // commit lands on the same edge that raises rsp_valid
  always_ff @(posedge clk) begin
    if (do_resp) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem_q[addr_al + ADDR_W'(i)] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32I core: the memory end of the datapath's load/store port. It accepts one load or store per handshake and services it after a programmable number of wait states. Stores are byte/half/word sized; load results are sign- or zero-extended per funct3. It replaces the ideal combinational data RAM so the core and future pipelined variants can be exercised against realistic memory latency.

## Interface
- ADDR_W, 7: byte-address width; memory depth is 2**ADDR_W bytes.
- WAIT_CYCLES, 0: wait states between acceptance and response, 0..15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: load 0/1/2/4/5 = LB/LH/LW/LBU/LHU; store 0/1/2 = SB/SH/SW.
- req_addr  in  ADDR_W  byte address; little-endian.
- req_wdata  in  32  store data, taken from the low bytes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected; no memory side effect.

## Operation
- FSM states:
  - IDLE: req_ready=1; on req_valid, capture we/funct3/addr/wdata into holding registers, then go to WAIT if WAIT_CYCLES>0, else to RESP.
  - WAIT: down-counter loaded with WAIT_CYCLES-1; go to RESP when the counter reaches 0.
  - RESP: perform the access, assert rsp_valid, return to IDLE.
- Responses have no backpressure: rsp_valid is high for exactly one cycle. req_ready is low in WAIT and RESP.
- Store byte lanes:
  - SB writes mem[a].
  - SH writes mem[a], mem[a+1].
  - SW writes mem[a..a+3].
- Load extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW returns mem[a+3..a] as {b3,b2,b1,b0}.
- Illegal funct3 (load 3/6/7, store ≥3): rsp_err=1, rsp_rdata=0, no write.
- Aligned accesses never cross the top of memory; there is no wrap-around case.
- Memory contents are zero at elaboration and are not cleared by reset.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter 0.
- Acceptance at edge T0 gives rsp_valid high in the cycle after edge T0+WAIT_CYCLES+1; the store commits on that same edge.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- rsp_rdata/rsp_err are registered and hold their last value until the next response. They are meaningful only while rsp_valid is high.
- req_valid while req_ready=0 is ignored; the requester must hold it.
- Reset asserted mid-transaction: the pending access is discarded, no write occurs, and no response is issued.
- A load following a store to the same address returns the new data, since accesses are strictly serialized.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: halfword at odd address or word with addr[1:0]≠0 gives rsp_err=1, rsp_rdata=0, no write.
- Undefined: low address bits are forced to alignment (half clears bit 0, word clears bits 1:0). The access proceeds normally and rsp_err flags only illegal funct3.

## Structure
- Shared package dmem_pkg holds:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - FSM state enum {IDLE, WAIT, RESP}.
  - The maximum WAIT_CYCLES constant.
- One sub-module, dmem_lane_ctrl (combinational), produces:
  - 4-bit byte-enable, aligned address and error flag from funct3/addr/we.
  - The extended load word from the four raw bytes.
- Top level holds the FSM, counter, holding registers and byte array.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
- After the above: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD.
- SH 0xAAAA1234 @0x12, then LW @0x10 -> 0x1234BEEF (upper half of wdata ignored).
- WAIT_CYCLES=3: accept at edge 0 -> req_ready low for 4 cycles, rsp_valid pulses in the cycle after edge 4, then req_ready=1.
- LW @0x11:
  - with DMEM_MISALIGN_TRAP_EN -> rsp_err=1, rdata=0.
  - without -> returns the word @0x10.
  - SW @0x11 with the macro leaves memory unchanged.
- SW 0x55 @0x20 accepted with WAIT_CYCLES=3, rst low for one cycle during WAIT -> no rsp_valid; subsequent LW @0x20 returns 0.
